// File: rtl/lab4_pkg.sv
// lab4_pkg: shared types and helpers for the lab 4 command sequencer.
//   state_t  : command FSM states
//   ASC_*    : ASCII constants used by the parser and responses
//   hex2nib  : ASCII hex digit -> {ok, nibble}
//   nib2hex  : nibble -> lowercase ASCII hex digit
package lab4_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, ENC, DEC_HI, DEC_LO, EMIT_LO, EMIT_LF
  } state_t;

  localparam logic [7:0] ASC_CR = 8'h0d;
  localparam logic [7:0] ASC_LF = 8'h0a;
  localparam logic [7:0] ASC_K  = 8'h4b;
  localparam logic [7:0] ASC_Q  = 8'h3f;
  localparam logic [7:0] ASC_L  = 8'h4c;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_D  = 8'h44;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } hex_t;

  function automatic hex_t hex2nib(input logic [7:0] c);
    hex_t h;
    h.ok  = 1'b1;
    h.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)
      h.nib = c[3:0];
    // 'a'..'f' and 'A'..'F' both have low nibble 1..6
    else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
      h.nib = c[3:0] + 4'd9;
    else
      h.ok = 1'b0;
    return h;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lab4_tx_fifo.sv
// lab4_tx_fifo: synchronous byte FIFO for the transmit path.
//   i_clk, i_rst_n : clock, async active-low reset (flushes contents)
//   i_push/i_wdata : write request; ignored when full
//   i_pop          : read request; ignored when empty
//   o_rdata        : head entry (first-word fall-through)
//   o_full/o_empty : occupancy flags
module lab4_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] r_mem;
  logic [AW-1:0]         r_wr, r_rd;
  logic [AW:0]           r_cnt;
  logic                  w_wr_en, w_rd_en;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_wr_en = i_push & ~o_full;
  assign w_rd_en = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_rd_en) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr_en} - {{AW{1'b0}}, w_rd_en};
    end
  end
endmodule

// File: rtl/lab4_cmd_ctrl.sv
// lab4_cmd_ctrl: UART command sequencer for the LFSR cipher.
//   L<8 hex>CR loads a seed, E<text>CR encrypts to hex, D<hex>CR decrypts.
//   clk12m, rst_n            : clock, async active-low reset
//   rx_data, rx_data_rdy     : received byte + strobe
//   tx_data, tx_data_rdy     : transmit FIFO head + pop strobe
//   tx_busy                  : transmitter busy, blocks pops
//   seed, ks_load            : committed seed + load pulse to datapath
//   ks, ks_adv               : keystream byte + advance pulse
//   ovf                      : sticky dropped-byte flag
// Build option: LAB4_CMD_ECHO_EN echoes accepted seed digits during LOAD.
module lab4_cmd_ctrl
  import lab4_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk12m,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_data_rdy,
  input  logic        tx_busy,
  output logic [31:0] seed,
  output logic        ks_load,
  input  logic [7:0]  ks,
  output logic        ks_adv,
  output logic        ovf
);
  state_t      r_state;
  logic [31:0] r_seed, r_seed_shadow;
  logic [3:0]  r_cnt, r_hi, r_lo;
  logic        r_cr_pend, r_ks_load, r_ovf;

  hex_t        w_hex;
  logic        w_is_cr, w_push, w_full, w_empty, w_pop;
  logic [7:0]  w_ct, w_pt, w_push_data;

  assign w_hex   = hex2nib(rx_data);
  assign w_is_cr = (rx_data == ASC_CR);
  assign w_ct    = rx_data ^ ks;
  assign w_pt    = {r_hi, w_hex.nib} ^ ks;

  // Push path and ks_adv are decoded from the current state so the FIFO
  // write and the keystream advance land on the same edge as the rx strobe.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 8'h00;
    ks_adv      = 1'b0;
    case (r_state)
      IDLE: if (rx_data_rdy && !w_is_cr &&
                rx_data != ASC_L && rx_data != ASC_E && rx_data != ASC_D) begin
        w_push = 1'b1; w_push_data = ASC_Q;
      end
      LOAD: if (rx_data_rdy) begin
        if (w_hex.ok && r_cnt < 4'd8) begin
`ifdef LAB4_CMD_ECHO_EN
          w_push = 1'b1; w_push_data = rx_data;
`endif
        end else begin
          w_push      = 1'b1;
          w_push_data = (w_is_cr && r_cnt == 4'd8) ? ASC_K : ASC_Q;
        end
      end
      ENC: if (rx_data_rdy) begin
        w_push = 1'b1;
        if (w_is_cr) w_push_data = ASC_CR;
        else begin
          w_push_data = nib2hex(w_ct[7:4]);
          ks_adv      = 1'b1;
        end
      end
      DEC_HI: if (rx_data_rdy && !w_hex.ok) begin
        w_push = 1'b1; w_push_data = w_is_cr ? ASC_CR : ASC_Q;
      end
      DEC_LO: if (rx_data_rdy) begin
        w_push = 1'b1;
        if (w_hex.ok) begin
          w_push_data = w_pt;
          ks_adv      = 1'b1;
        end else w_push_data = ASC_Q;
      end
      EMIT_LO: begin w_push = 1'b1; w_push_data = nib2hex(r_lo); end
      EMIT_LF: begin w_push = 1'b1; w_push_data = r_cr_pend ? ASC_CR : ASC_LF; end
      default: ;
    endcase
  end

  // r_cr_pend: EMIT_LF still owes a CR before the LF (after '?' or 'K').
  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_seed        <= '0;
      r_seed_shadow <= '0;
      r_cnt         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_cr_pend     <= 1'b0;
      r_ks_load     <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_ks_load <= 1'b0;
      r_ovf     <= r_ovf | (w_push & w_full) |
                   (rx_data_rdy & (r_state == EMIT_LO || r_state == EMIT_LF));
      case (r_state)
        IDLE: if (rx_data_rdy) begin
          if (rx_data == ASC_L) begin r_state <= LOAD; r_cnt <= '0; end
          else if (rx_data == ASC_E) r_state <= ENC;
          else if (rx_data == ASC_D) r_state <= DEC_HI;
          else if (!w_is_cr) begin r_state <= EMIT_LF; r_cr_pend <= 1'b1; end
        end
        LOAD: if (rx_data_rdy) begin
          if (w_hex.ok && r_cnt < 4'd8) begin
            r_seed_shadow <= {r_seed_shadow[27:0], w_hex.nib};
            r_cnt         <= r_cnt + 4'd1;
          end else begin
            if (w_is_cr && r_cnt == 4'd8) begin
              r_seed    <= r_seed_shadow;
              r_ks_load <= 1'b1;
            end
            r_state   <= EMIT_LF;
            r_cr_pend <= 1'b1;
          end
        end
        ENC: if (rx_data_rdy) begin
          if (w_is_cr) begin r_state <= EMIT_LF; r_cr_pend <= 1'b0; end
          else begin r_lo <= w_ct[3:0]; r_state <= EMIT_LO; end
        end
        DEC_HI: if (rx_data_rdy) begin
          if (w_hex.ok) begin r_hi <= w_hex.nib; r_state <= DEC_LO; end
          else begin r_state <= EMIT_LF; r_cr_pend <= !w_is_cr; end
        end
        DEC_LO: if (rx_data_rdy) begin
          if (w_hex.ok) r_state <= DEC_HI;
          else begin r_state <= EMIT_LF; r_cr_pend <= 1'b1; end
        end
        EMIT_LO: r_state <= ENC;
        EMIT_LF: begin
          if (r_cr_pend) r_cr_pend <= 1'b0;
          else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_pop       = ~w_empty & ~tx_busy;
  assign tx_data_rdy = w_pop;
  assign seed        = r_seed;
  assign ks_load     = r_ks_load;
  assign ovf         = r_ovf;

  lab4_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk12m),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_lab4_cmd_ctrl.sv
// tb_lab4_cmd_ctrl: directed bench with a keystream datapath model and an
// expected-byte queue checked against every transmit pop.
module tb_lab4_cmd_ctrl;
  localparam int DEPTH = 8;

  logic        clk12m = 1'b0;
  logic        rst_n  = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_data_rdy;
  logic [7:0]  tx_data;
  logic        tx_data_rdy;
  logic        tx_busy;
  logic [31:0] seed;
  logic        ks_load;
  logic [7:0]  ks;
  logic        ks_adv;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  int          n_adv  = 0;
  int          n_load = 0;
  int          adv0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  logic [31:0] ks_st;
  logic [31:0] mks;
  string       hx = "0123456789abcdef";

  always #5 clk12m = ~clk12m;

  lab4_cmd_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk12m      (clk12m),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .tx_data     (tx_data),
    .tx_data_rdy (tx_data_rdy),
    .tx_busy     (tx_busy),
    .seed        (seed),
    .ks_load     (ks_load),
    .ks          (ks),
    .ks_adv      (ks_adv),
    .ovf         (ovf)
  );

  function automatic logic [31:0] step(input logic [31:0] x);
    return {x[30:0], 1'b0} ^ (x[31] ? 32'h04c11db7 : 32'h0);
  endfunction

  // Keystream datapath stand-in
  assign ks = ks_st[7:0];
  always @(posedge clk12m or negedge rst_n)
    if (!rst_n)       ks_st <= 32'h0;
    else if (ks_load) ks_st <= seed;
    else if (ks_adv)  ks_st <= step(ks_st);

  // Transmit monitor: each cycle with tx_data_rdy high is one pop.
  always @(negedge clk12m) begin
    if (ks_adv)  n_adv++;
    if (ks_load) n_load++;
    if (rst_n && tx_data_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_tx obs=%02h exp=none", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        assert (tx_data === mon_exp) else begin
          errors++;
          $error("FAIL tx_byte obs=%02h exp=%02h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Bytes beyond FIFO capacity are dropped by the DUT; only meaningful
  // while the transmitter is held busy.
  task automatic push_exp(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  task automatic resp(input logic [7:0] b);
    push_exp(b); push_exp(8'h0d); push_exp(8'h0a);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk12m); #1;
    rx_data = b; rx_data_rdy = 1'b1;
    @(posedge clk12m); #1;
    rx_data_rdy = 1'b0;
    repeat (3) @(posedge clk12m);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk12m); n++;
    end
    repeat (4) @(posedge clk12m);
    chk({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_hex(input string s, input logic [7:0] rsp);
    send(8'h4c);
    for (int i = 0; i < s.len(); i++) begin
`ifdef LAB4_CMD_ECHO_EN
      push_exp(s[i]);
`endif
      send(s[i]);
    end
    resp(rsp);
    send(8'h0d);
  endtask

  task automatic enc_str(input string s);
    logic [7:0] p, c;
    for (int i = 0; i < s.len(); i++) begin
      p = s[i];
      c = p ^ mks[7:0];
      mks = step(mks);
      push_exp(hx[c[7:4]]);
      push_exp(hx[c[3:0]]);
      send(p);
    end
  endtask

  task automatic dec_str(input string s);
    logic [7:0] p, c;
    for (int i = 0; i < s.len(); i++) begin
      p = s[i];
      c = p ^ mks[7:0];
      mks = step(mks);
      send(hx[c[7:4]]);
      push_exp(p);
      send(hx[c[3:0]]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rx_data = 8'h00; rx_data_rdy = 1'b0; tx_busy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk12m); #1;
    chk("rst_seed", seed, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_rdy", tx_data_rdy, 0);
    chk("rst_ks_load", ks_load, 0);
    chk("rst_ks_adv", ks_adv, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    // seed of all zeros
    load_hex("00000000", 8'h4b); drain("load0");
    chk("load0_seed", seed, 32'h0);
    chk("load0_pulses", n_load, 1);

    // valid seed
    load_hex("12345678", 8'h4b); drain("load1");
    chk("load1_seed", seed, 32'h12345678);
    chk("load1_pulses", n_load, 2);
    mks = 32'h12345678;

    // encrypt
    adv0 = n_adv;
    send(8'h45);
    enc_str("abcd!");
    push_exp(8'h0d); push_exp(8'h0a);
    send(8'h0d); drain("enc");
    chk("enc_adv", n_adv - adv0, 5);
    chk("enc_ovf", ovf, 0);

    // reseed, decrypt the same ciphertext
    load_hex("12345678", 8'h4b); drain("reload");
    mks = 32'h12345678;
    adv0 = n_adv;
    send(8'h44);
    dec_str("abcd!");
    push_exp(8'h0d); push_exp(8'h0a);
    send(8'h0d); drain("dec");
    chk("dec_adv", n_adv - adv0, 5);
    chk("dec_pulses", n_load, 3);

    // odd digit count
    send(8'h44); send(8'h34);
    resp(8'h3f); send(8'h0d); drain("dec_odd");

    // short seed
    load_hex("123", 8'h3f); drain("load_short");
    chk("short_seed", seed, 32'h12345678);
    chk("short_pulses", n_load, 3);

    // non-hex in LOAD, then a stray byte in IDLE
    send(8'h4c);
    resp(8'h3f); send(8'h7a);
    resp(8'h3f); send(8'h5a);
    drain("load_bad");
    chk("bad_seed", seed, 32'h12345678);

    // ninth digit
    begin
      string d9 = "87654321";
      send(8'h4c);
      for (int i = 0; i < d9.len(); i++) begin
`ifdef LAB4_CMD_ECHO_EN
        push_exp(d9[i]);
`endif
        send(d9[i]);
      end
      resp(8'h3f); send(8'h39);
      drain("load_nine");
      chk("nine_seed", seed, 32'h12345678);
      chk("nine_pulses", n_load, 3);
    end

    // backpressure: FIFO fills, later bytes dropped
    @(posedge clk12m); #1 tx_busy = 1'b1;
    send(8'h45);
    enc_str("ABCDEFGH");
    push_exp(8'h0d); push_exp(8'h0a);
    send(8'h0d);
    chk("bp_ovf", ovf, 1);
    chk("bp_rdy_busy", tx_data_rdy, 0);
    chk("bp_queued", exp_q.size(), DEPTH);
    @(posedge clk12m); #1 tx_busy = 1'b0;
    drain("bp");

    // reset mid-command with bytes stuck in the FIFO
    @(posedge clk12m); #1 tx_busy = 1'b1;
    send(8'h78);
    send(8'h4c); send(8'h31); send(8'h32);
    @(posedge clk12m); #1 rst_n = 1'b0;
    #1;
    chk("mid_seed", seed, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_tx_rdy", tx_data_rdy, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_ks_load", ks_load, 0);
    chk("mid_ks_adv", ks_adv, 0);
    exp_q.delete();
    tx_busy = 1'b0;
    repeat (2) @(posedge clk12m); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk12m);
    chk("flush_rdy", tx_data_rdy, 0);

    load_hex("00000001", 8'h4b); drain("post_rst");
    chk("post_seed", seed, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
